// File: rtl/bias_add.sv
// Registered saturating bias adder: dn_data is sat(up_data + bias) one clock
// after the operands are presented. The binary point does not affect the math.
module bias_add #(
    parameter int NUM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WIDTH-1:0] bias,
    input  logic [NUM_WIDTH-1:0] up_data,
    output logic [NUM_WIDTH-1:0] dn_data
);

    localparam int MSB = NUM_WIDTH - 1;

    // The top two bits of the one-bit-wider sum differ only on overflow, and
    // the top bit then gives the direction of the clamp.
    function automatic logic [NUM_WIDTH-1:0] sat_sum(input logic [NUM_WIDTH:0] s);
        logic [NUM_WIDTH-1:0] r;
        if (s[NUM_WIDTH] != s[NUM_WIDTH-1]) begin
            if (s[NUM_WIDTH]) begin
                r = {1'b1, {(NUM_WIDTH-1){1'b0}}};
            end else begin
                r = {1'b0, {(NUM_WIDTH-1){1'b1}}};
            end
        end else begin
            r = s[NUM_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [NUM_WIDTH:0]   sum_s;
    logic [NUM_WIDTH-1:0] sat_s;
    logic [NUM_WIDTH-1:0] dn_data_r;

    // Sign-extended sum followed by the saturation clamp.
    always_comb begin
        sum_s = {up_data[MSB], up_data} + {bias[MSB], bias};
        sat_s = sat_sum(sum_s);
    end

    // The result register is the only state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_data_r <= {NUM_WIDTH{1'b0}};
        end else begin
            dn_data_r <= sat_s;
        end
    end

    assign dn_data = dn_data_r;

endmodule

// File: tb/tb_bias_add.sv
// Self-checking bench for bias_add: directed Q8.8 scenarios plus randomized
// operands compared against an integer-arithmetic reference.
module tb_bias_add;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] bias;
    logic [W-1:0] up_data;
    logic [W-1:0] dn_data;

    int n_checks = 0;
    int n_fail   = 0;

    bias_add #(.NUM_WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bias    (bias),
        .up_data (up_data),
        .dn_data (dn_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true integer sum, clamped to the signed W-bit range.
    function automatic logic [W-1:0] ref_sat(input logic [W-1:0] u, input logic [W-1:0] b);
        int s;
        s = int'($signed(u)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[W-1:0];
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operand pair, clock it in, check the result #1 after the edge.
    task automatic step(input string tag, input logic [W-1:0] u, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
        up_data = u;
        bias    = b;
        @(posedge clk);
        #1;
        check_val(tag, dn_data, exp);
    endtask

    initial begin
        logic [W-1:0] u;
        logic [W-1:0] b;

        rst_n   = 1'b0;
        bias    = 16'h1234;
        up_data = 16'h4321;
        #1;
        check_val("reset_async", dn_data, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", dn_data, 16'h0000);

        // First edge after release loads the current sum immediately.
        rst_n = 1'b1;
        step("reset_first", 16'h0100, 16'h0280, 16'h0380);

        for (int i = 1; i <= 20; i++) begin
            step("ramp", 16'(i * 256), 16'h0280, 16'(16'h0380 + (i - 1) * 256));
        end

        step("pos_sat",   16'h7F00, 16'h0280, 16'h7FFF);
        step("pos_nosat", 16'h7D00, 16'h0280, 16'h7F80);
        step("neg_sat",   16'h8100, 16'hFD80, 16'h8000);
        step("neg_nosat", 16'hFF00, 16'hFD80, 16'hFC80);
        step("max_max",   16'h7FFF, 16'h7FFF, 16'h7FFF);
        step("min_min",   16'h8000, 16'h8000, 16'h8000);
        step("edge_max",  16'h7FFE, 16'h0001, 16'h7FFF);
        step("edge_min",  16'h8001, 16'hFFFF, 16'h8000);
        step("mixed",     16'h8000, 16'h7FFF, 16'hFFFF);

        step("bias_chg0", 16'h0100, 16'h0280, 16'h0380);
        step("bias_chg1", 16'h0100, 16'h0000, 16'h0100);

        for (int i = 0; i < 4; i++) begin
            step("idle", 16'h0000, 16'h0280, 16'h0280);
        end

        // Mid-ramp reset between edges clears the output at once.
        step("ramp_pre", 16'h0500, 16'h0280, 16'h0780);
        up_data = 16'h0600;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_mid", dn_data, 16'h0000);
        @(posedge clk);
        #1;
        check_val("reset_mid_hold", dn_data, 16'h0000);
        up_data = 16'h0700;
        #2;
        rst_n = 1'b1;
        step("reset_release", 16'h0700, 16'h0280, 16'h0980);

        for (int i = 0; i < 300; i++) begin
            u = 16'($urandom);
            b = 16'($urandom);
            if (i % 4 == 1) u = {u[15], {3{u[15]}}, u[11:0]};
            step("random", u, b, ref_sat(u, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
